// File: rtl/systolic_feeder.sv
// Operand feeder for the 3x3 output-stationary PE array: stores A/B, emits skewed row/column streams.
// Optional SYSTOLIC_FEEDER_WR_ERR_EN adds a sticky wr_err flag for dropped writes.
module systolic_feeder #(
  parameter int DATA_W       = 8,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [1:0]        wr_row,
  input  logic [1:0]        wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] a0,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] a2,
  output logic [DATA_W-1:0] b0,
  output logic [DATA_W-1:0] b1,
  output logic [DATA_W-1:0] b2
`ifdef SYSTOLIC_FEEDER_WR_ERR_EN
  ,
  output logic              wr_err
`endif
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t            state, state_n;
  logic [2:0]        step, step_n;
  logic [DW-1:0]     drain, drain_n;
  logic              load, done_n, wr_ok;
  logic [DATA_W-1:0] a_mem [3][3];
  logic [DATA_W-1:0] b_mem [3][3];
  logic [DATA_W-1:0] a_q [3];
  logic [DATA_W-1:0] b_q [3];
  logic [DATA_W-1:0] a_n [3];
  logic [DATA_W-1:0] b_n [3];

  assign wr_ok = wr_en && !busy;

  always_comb begin
    state_n = state;
    step_n  = step;
    drain_n = drain;
    load    = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = FEED;
          step_n  = 3'd0;
          load    = 1'b1;
        end
      end
      FEED: begin
        if (step == 3'd4) begin
          state_n = DRAIN;
          drain_n = '0;
        end else begin
          step_n = step + 3'd1;
          load   = 1'b1;
        end
      end
      DRAIN: begin
        if (drain == DW'(DRAIN_CYCLES - 1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
          drain_n = '0;
        end else begin
          drain_n = drain + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Skew: row i sees A[i][t-i], column j sees B[t-j][j]; pre-edge storage is used.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      a_n[i] = '0;
      b_n[i] = '0;
      for (int k = 0; k < 3; k++) begin
        if (load && step_n == 3'(i + k)) begin
          a_n[i] = a_mem[i][k];
          b_n[i] = b_mem[k][i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= '0;
      drain <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      state <= state_n;
      step  <= step_n;
      drain <= drain_n;
      busy  <= (state_n != IDLE);
      done  <= done_n;
      for (int i = 0; i < 3; i++) begin
        a_q[i] <= a_n[i];
        b_q[i] <= b_n[i];
      end
    end
  end

  // Index value 3 never matches a loop position, so such writes fall through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          if (wr_ok && wr_row == 2'(r) && wr_col == 2'(c)) begin
            if (wr_sel) b_mem[r][c] <= wr_data;
            else        a_mem[r][c] <= wr_data;
          end
        end
      end
    end
  end

  assign a0 = a_q[0];
  assign a1 = a_q[1];
  assign a2 = a_q[2];
  assign b0 = b_q[0];
  assign b1 = b_q[1];
  assign b2 = b_q[2];

`ifdef SYSTOLIC_FEEDER_WR_ERR_EN
  logic wr_drop;
  assign wr_drop = wr_en && (busy || wr_row == 2'd3 || wr_col == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        wr_err <= 1'b0;
    else if (wr_drop)                  wr_err <= 1'b1;
    else if (state == IDLE && start)   wr_err <= 1'b0;
  end
`endif

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream operand stage for the 3x3 output-stationary PE_array.
- Holds a 3x3 A matrix and a 3x3 B matrix, loaded through a simple write port.
- On start, drives the diagonally skewed a0..a2 / b0..b2 streams the array expects, then waits a drain window and pulses done when C results are final.
- Outputs connect directly to PE_array a*/b* inputs.

Parameters:
- DATA_W, 8, operand width in bits (signed two's complement).
- DRAIN_CYCLES, 8, zero-fill cycles after the last skewed step before done (must be >= 1; 8 covers propagation to PE(2,2)).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  operand write strobe
- wr_sel  in  1  0 = write A, 1 = write B
- wr_row  in  2  row index 0..2
- wr_col  in  2  column index 0..2
- wr_data  in  DATA_W  signed operand value
- start  in  1  begin feed sequence (level sampled)
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, results valid in PE_array
- a0, a1, a2  out  DATA_W  signed row streams to PE_array
- b0, b1, b2  out  DATA_W  signed column streams to PE_array

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0; a0..a2=0, b0..b2=0; all 18 storage entries cleared to 0; step and drain counters cleared. Reset mid-sequence aborts immediately with no done pulse.
- Storage writes:
  - Accepted on a rising edge when wr_en=1, busy=0 and wr_row, wr_col <= 2.
  - Index value 3 is ignored.
  - Writes while busy=1 are dropped.
- States IDLE -> FEED -> DRAIN -> IDLE. All outputs are registered.
- IDLE:
  - Outputs held at 0.
  - start=1 at edge E0 moves to FEED with step t=0, busy=1, and loads the step-0 values onto a*/b* at E0.
- FEED, step t=0..4, loaded at edge Et:
  - a_i = A[i][t-i] when 0 <= t-i <= 2, else 0.
  - b_j = B[t-j][j] when 0 <= t-j <= 2, else 0.
  - At E5: all outputs go to 0, state DRAIN, drain counter=0.
- DRAIN:
  - Outputs stay 0.
  - Counter increments each edge.
  - At edge E(5+DRAIN_CYCLES): state IDLE, busy=0, done=1 for exactly one cycle.
- start while busy=1 is ignored. start in the cycle done=1 is accepted (state is IDLE) and begins a new sequence.
- wr_en and start on the same edge in IDLE: the write lands, but step 0 uses the pre-write storage contents. The new value appears in later steps if its position is read then.
- Operands pass through unmodified. No arithmetic, no width change.
- Storage persists across sequences until overwritten or reset.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_WR_ERR_EN.
- Defined:
  - Adds output wr_err (1 bit, reset 0).
  - Sticky; set on any edge where wr_en=1 and the write is dropped (busy=1 or index 3).
  - Cleared on the edge a start is accepted, unless a dropped write occurs on that same edge, in which case it stays 1.
- Undefined: port absent; dropped writes are silent.

Test Plan:
- Load A=[1 2 3;4 5 6;7 8 9], B=[9 6 3;8 5 2;7 4 1], pulse start -> over E0..E4 expect:
  - a0 = 1,2,3,0,0; a1 = 0,4,5,6,0; a2 = 0,0,7,8,9
  - b0 = 9,8,7,0,0; b1 = 0,6,5,4,0; b2 = 0,0,3,2,1
  - All outputs 0 from E5; busy high E0..E12; done high only after E13.
- Feeder driving PE_array (fresh reset), same matrices -> at done: c00..c22 = 46 28 10 / 118 73 28 / 190 118 46.
- A all -128, B all 127 -> a*/b* carry -128/127 unchanged in their skew slots; with PE_array, every c = -48768.
- Write A[0][0]=5 while busy, plus a write with wr_row=3 -> storage unchanged; second run shows a0=1 at E0; with SYSTOLIC_FEEDER_WR_ERR_EN, wr_err=1 until the next accepted start.
- Assert rst_n=0 at step t=2 -> outputs, busy and done go 0 immediately; no done pulse; storage reads back 0 on the next run.
- Start asserted continuously -> new sequence begins at the edge after done (done and the new E0 coincide); start held during busy causes no restart.
